// File: rtl/mem_access_ctrl.sv
// Sequencer for the MAR/MDR memory path: turns a one-cycle read/write request into MAR/MDR/memory strobes.
// Optional wait-state timeout (abort to ERR with an err pulse) is built only when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req_rd,
    input  logic       req_wr,
    input  logic       mem_rdy,
    output logic       mar_in,
    output logic       mdr_in,
    output logic       mdr_read,
    output logic       mdr_out,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_DONE = 3'd3,
        S_WR_LOAD = 3'd4,
        S_WR_WAIT = 3'd5,
        S_WR_DONE = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   is_rd_q, is_rd_d;
    logic   timeout_hit;

    // Handshake: a request is a level sampled only while IDLE (busy=0); the memory side
    // completes a wait state in any cycle where mem_rdy=1, and completion is a one-cycle done.
    always_comb begin
        state_d = state_q;
        is_rd_d = is_rd_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_rd || req_wr) begin
                    state_d = S_ADDR;
                    is_rd_d = req_rd;
                end
            end
            S_ADDR:    state_d = is_rd_q ? S_RD_WAIT : S_WR_LOAD;
            S_RD_WAIT: begin
                if (mem_rdy)          state_d = S_RD_DONE;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_RD_DONE: state_d = S_IDLE;
            S_WR_LOAD: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_rdy)          state_d = S_WR_DONE;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_WR_DONE: state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts on every entry into a wait state and only advances while staying there.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_RD_WAIT) || (state_q == S_WR_WAIT))) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout_hit = (cnt_q == CNT_LIM);
`else
    // Sizing parameters only matter when the timeout logic is present.
    logic [CNT_W-1:0] unused_cfg;
    assign unused_cfg  = CNT_W'(TIMEOUT);
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        mdr_read = 1'b0;
        mdr_out  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE:    ;
            S_ADDR:    mar_in = 1'b1;
            S_RD_WAIT: begin
                mem_rd   = 1'b1;
                mdr_read = 1'b1;
                mdr_in   = mem_rdy;
            end
            S_RD_DONE: begin
                mdr_out = 1'b1;
                done    = 1'b1;
            end
            S_WR_LOAD: mdr_in = 1'b1;
            S_WR_WAIT: mem_wr = 1'b1;
            S_WR_DONE: done = 1'b1;
            S_ERR: begin
`ifdef MEM_TIMEOUT_EN
                err = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a timeline model per transaction fills a per-cycle output
// map and a completion queue; a negedge monitor compares every cycle and every done/err pulse.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       clr, req_rd, req_wr, mem_rdy;
    logic       mar_in, mdr_in, mdr_read, mdr_out, mem_rd, mem_wr, busy, done, err;
    logic [2:0] state_o;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .clr(clr), .req_rd(req_rd), .req_wr(req_wr), .mem_rdy(mem_rdy),
        .mar_in(mar_in), .mdr_in(mdr_in), .mdr_read(mdr_read), .mdr_out(mdr_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done), .err(err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [11:0] exp_out [int];
    logic [33:0] exp_q[$];
    logic [11:0] vec_q[$];
    bit          rdy_q[$];
    bit          clr_q[$];

    // Vector layout: {state, busy, mar_in, mdr_in, mdr_read, mdr_out, mem_rd, mem_wr, done, err}
    function automatic logic [11:0] v(input int st, input bit mar, input bit mdi, input bit mdrd,
                                      input bit mdo, input bit mrd, input bit mwr, input bit dn,
                                      input bit er);
        logic [2:0] s;
        s = st[2:0];
        return {s, (st != 0), mar, mdi, mdrd, mdo, mrd, mwr, dn, er};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [11:0] obs;
        logic [11:0] expv;
        logic [33:0] e;
        if (mon_en) begin
            obs  = {state_o, busy, mar_in, mdr_in, mdr_read, mdr_out, mem_rd, mem_wr, done, err};
            expv = exp_out.exists(cyc) ? exp_out[cyc] : 12'h000;
            check("outputs", {22'd0, obs}, {22'd0, expv});
            if (done === 1'b1 || err === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL completion at cycle %0d: got done=%b err=%b, expected no completion",
                             cyc, done, err);
                end else begin
                    e = exp_q.pop_front();
                    check("completion", {err, mdr_out, 32'(cyc)}, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            mem_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    // Caller guarantees the DUT is idle in the current cycle; waits = cycles mem_rdy stays low,
    // clr_k = wait-cycle index at which clr is pulsed (-1 for none).
    task automatic run_txn(input bit rd, input bit wr, input int waits, input int clr_k);
        int e0;
        bit is_rd, cleared, timed_out, hit;
        vec_q.delete();
        rdy_q.delete();
        clr_q.delete();
        is_rd     = rd;
        cleared   = 1'b0;
        timed_out = 1'b0;
        vec_q.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0));
        rdy_q.push_back(1'($urandom_range(0, 1)));
        clr_q.push_back(1'b0);
        if (!is_rd) begin
            vec_q.push_back(v(4, 0, 1, 0, 0, 0, 0, 0, 0));
            rdy_q.push_back(1'($urandom_range(0, 1)));
            clr_q.push_back(1'b0);
        end
        for (int k = 0; k < 100000; k++) begin
            hit = (k == waits);
            vec_q.push_back(is_rd ? v(2, 0, hit, 1, 0, 1, 0, 0, 0) : v(5, 0, 0, 0, 0, 0, 1, 0, 0));
            rdy_q.push_back(hit);
            clr_q.push_back(k == clr_k);
            if (k == clr_k) begin
                cleared = 1'b1;
                break;
            end
            if (hit) break;
`ifdef MEM_TIMEOUT_EN
            if (k == TIMEOUT - 1) begin
                timed_out = 1'b1;
                break;
            end
`endif
        end
        if (!cleared) begin
            if (timed_out)  vec_q.push_back(v(7, 0, 0, 0, 0, 0, 0, 0, 1));
            else if (is_rd) vec_q.push_back(v(3, 0, 0, 0, 1, 0, 0, 1, 0));
            else            vec_q.push_back(v(6, 0, 0, 0, 0, 0, 0, 1, 0));
            rdy_q.push_back(1'($urandom_range(0, 1)));
            clr_q.push_back(1'b0);
        end
        e0 = cyc + 1;
        for (int i = 0; i < vec_q.size(); i++) exp_out[e0 + i] = vec_q[i];
        if (!cleared) exp_q.push_back({timed_out, is_rd && !timed_out, 32'(e0 + vec_q.size() - 1)});

        req_rd = rd;
        req_wr = wr;
        for (int i = 0; i < vec_q.size(); i++) begin
            @(posedge clk);
            #1;
            mem_rdy = rdy_q[i];
            clr     = clr_q[i];
            req_rd  = 1'($urandom_range(0, 1));
            req_wr  = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        clr     = 1'b0;
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        mem_rdy = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, waits, clr_k;
        clr     = 1'b1;
        req_rd  = 1'b0;
        req_wr  = 1'b0;
        mem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        run_txn(1, 0, 0, -1);
        run_txn(0, 1, 3, -1);
        run_txn(1, 1, 1, -1);
        run_txn(1, 0, 10, 2);
        run_txn(0, 1, 0, -1);
        idle(2);
        run_txn(1, 0, 100, -1);
        run_txn(1, 0, TIMEOUT - 1, -1);
        run_txn(0, 1, TIMEOUT, -1);
        run_txn(0, 1, 2, 1);
        idle(1);

        repeat (40) begin
            kind  = $urandom_range(0, 2);
            waits = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                                : $urandom_range(0, 4);
            clr_k = ($urandom_range(0, 7) == 0) ? $urandom_range(0, waits) : -1;
            run_txn(kind != 1, kind != 0, waits, clr_k);
            idle($urandom_range(0, 2));
        end
        idle(3);

        check("queue_drained", 34'(exp_q.size()), 34'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
